// File: rtl/axi_rd_arbiter.sv
// Single-outstanding AXI3 read arbiter sharing one read port between I-cache and D-cache refills.
// Optional BEAT_CHK_EN adds a sticky beat_err flag comparing bus rlast against the expected beat count.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [2:0]  ISIZE  = 3'b010
) (
  input  logic              clk,
  input  logic              resetn,
  // I-cache refill port
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [3:0]        i_arlen,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  output logic              i_rvalid,
  input  logic              i_rready,
  // D-cache refill port
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [3:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  output logic              d_rvalid,
  input  logic              d_rready,
  // AXI3 read address channel
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // AXI3 read data channel
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy
`ifdef BEAT_CHK_EN
  ,
  output logic              beat_err
`endif
);

  localparam int unsigned LEN_W  = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic owner;      // 1 = D-cache owns the current burst
  logic grant_d;
  logic grant_i;
  logic r_hs;
  logic in_data;

  // Routing never depends on rid/rresp; keep them visibly consumed.
  logic unused_rsp;
  assign unused_rsp = ^{rid, rresp};

  // Constant address-channel attributes.
  assign arid    = {(ID_W-1)'(0), owner};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshakes and bus control; D-cache has fixed priority.
  always_comb begin
    state_nxt = state;
    i_arready = 1'b0;
    d_arready = 1'b0;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    r_hs      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (d_arvalid) begin
          d_arready = 1'b1;
          grant_d   = 1'b1;
          state_nxt = ADDR;
        end else if (i_arvalid) begin
          i_arready = 1'b1;
          grant_i   = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        rready = owner ? d_rready : i_rready;
        r_hs   = rvalid & rready;
        if (r_hs && rlast) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the winner's request fields on the grant edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      araddr <= '0;
      arlen  <= '0;
      arsize <= '0;
      owner  <= 1'b0;
    end else if (grant_d) begin
      araddr <= d_araddr;
      arlen  <= d_arlen;
      arsize <= d_arsize;
      owner  <= 1'b1;
    end else if (grant_i) begin
      araddr <= i_araddr;
      arlen  <= i_arlen;
      arsize <= ISIZE;
      owner  <= 1'b0;
    end
  end

  // R channel steering: only the owner sees beats, and only during DATA.
  assign in_data = (state == DATA);

  always_comb begin
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rlast  = 1'b0;
    d_rdata  = '0;
    if (in_data) begin
      if (owner) begin
        d_rvalid = rvalid;
        d_rlast  = rlast;
        d_rdata  = rdata;
      end else begin
        i_rvalid = rvalid;
        i_rlast  = rlast;
        i_rdata  = rdata;
      end
    end
  end

`ifdef BEAT_CHK_EN
  logic [LEN_W-1:0] beat_cnt;

  // Beat counter restarts on address acceptance; beat_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt <= '0;
      beat_err <= 1'b0;
    end else begin
      if ((state == ADDR) && arready) begin
        beat_cnt <= '0;
      end else if (r_hs) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (r_hs && (rlast != (beat_cnt == arlen))) begin
        beat_err <= 1'b1;
      end
    end
  end
`else
  logic [SIZE_W-1:0] unused_size;
  assign unused_size = '0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (honours BEAT_CHK_EN when defined).
module tb_axi_rd_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic [ADDR_W-1:0] i_araddr, d_araddr;
  logic [3:0]        i_arlen, d_arlen;
  logic [2:0]        d_arsize;
  logic              i_arvalid, d_arvalid;
  logic              i_arready, d_arready;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              i_rlast, d_rlast, i_rvalid, d_rvalid;
  logic              i_rready, d_rready;
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst, arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid, arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready, busy;
`ifdef BEAT_CHK_EN
  logic              beat_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy)
`ifdef BEAT_CHK_EN
    , .beat_err(beat_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n beats to the owner; rlast on beat last_idx; optional 3-cycle owner stall before stall_at.
  task automatic run_beats(input bit own_d, input int n, input int last_idx,
                           input logic [31:0] base, input int stall_at);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          rvalid = 1'b1; rdata = base + 32'(k); rlast = (k == last_idx);
          i_rready = own_d; d_rready = !own_d;
          #1;
          check("stall_rready", 64'(rready), 64'(0));
          check("stall_i_rvalid", 64'(i_rvalid), own_d ? 64'(0) : 64'(1));
          check("stall_busy", 64'(busy), 64'(1));
          tick();
        end
      end
      rvalid = 1'b1; rdata = base + 32'(k); rlast = (k == last_idx);
      i_rready = 1'b1; d_rready = 1'b1;
      #1;
      check("beat_rready", 64'(rready), 64'(1));
      check("beat_own_rvalid", 64'(own_d ? d_rvalid : i_rvalid), 64'(1));
      check("beat_own_rdata", 64'(own_d ? d_rdata : i_rdata), 64'(base + 32'(k)));
      check("beat_own_rlast", 64'(own_d ? d_rlast : i_rlast), 64'(k == last_idx));
      check("beat_oth_rvalid", 64'(own_d ? i_rvalid : d_rvalid), 64'(0));
      check("beat_oth_rdata", 64'(own_d ? i_rdata : d_rdata), 64'(0));
      check("beat_no_arready", 64'(i_arready | d_arready), 64'(0));
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; i_rready = 1'b0; d_rready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    i_araddr = '0; i_arlen = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_arvalid", 64'(arvalid), 64'(0));
    check("rst_rready", 64'(rready), 64'(0));
    check("rst_araddr", 64'(araddr), 64'(0));
    check("rst_arlen_size_id", 64'({arlen, arsize, arid}), 64'(0));
    check("rst_xvalid", 64'({i_rvalid, d_rvalid, i_rlast, d_rlast, i_arready, d_arready}), 64'(0));
`ifdef BEAT_CHK_EN
    check("rst_beat_err", 64'(beat_err), 64'(0));
`endif
    resetn = 1'b1;
    tick();

    // Single I-cache burst.
    i_araddr = 32'h1FC0_0000; i_arlen = 4'd7; i_arvalid = 1'b1;
    #1;
    check("t1_i_arready", 64'(i_arready), 64'(1));
    check("t1_d_arready", 64'(d_arready), 64'(0));
    check("t1_c0_arvalid", 64'(arvalid), 64'(0));
    tick();
    i_arvalid = 1'b0;
    #1;
    check("t1_arvalid", 64'(arvalid), 64'(1));
    check("t1_araddr", 64'(araddr), 64'h1FC0_0000);
    check("t1_arlen", 64'(arlen), 64'(7));
    check("t1_arsize", 64'(arsize), 64'(2));
    check("t1_arid", 64'(arid), 64'(0));
    check("t1_arburst", 64'(arburst), 64'(1));
    check("t1_arconst", 64'({arlock, arcache, arprot}), 64'(0));
    check("t1_busy", 64'(busy), 64'(1));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    run_beats(1'b0, 8, 7, 32'hA000_0000, -1);
    #1;
    check("t1_busy_end", 64'(busy), 64'(0));
    check("t1_arvalid_end", 64'(arvalid), 64'(0));

    // Stray beat while idle is neither consumed nor forwarded.
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_BEEF; i_rready = 1'b1; d_rready = 1'b1;
    #1;
    check("stray_rready", 64'(rready), 64'(0));
    check("stray_xvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
    check("stray_i_rdata", 64'(i_rdata), 64'(0));
    tick();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; i_rready = 1'b0; d_rready = 1'b0;
    check("stray_busy", 64'(busy), 64'(0));

    // Simultaneous requests: D first, I held through D's burst.
    d_araddr = 32'h8000_1000; d_arlen = 4'd3; d_arsize = 3'd2; d_arvalid = 1'b1;
    i_araddr = 32'h8000_2000; i_arlen = 4'd7; i_arvalid = 1'b1;
    #1;
    check("t2_d_arready", 64'(d_arready), 64'(1));
    check("t2_i_arready", 64'(i_arready), 64'(0));
    tick();
    d_arvalid = 1'b0;
    #1;
    check("t2_arid_d", 64'(arid), 64'(1));
    check("t2_araddr_d", 64'(araddr), 64'h8000_1000);
    check("t2_arlen_d", 64'(arlen), 64'(3));
    check("t2_arsize_d", 64'(arsize), 64'(2));
    check("t2_addr_arready", 64'(i_arready | d_arready), 64'(0));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    run_beats(1'b1, 4, 3, 32'hD000_0000, 1);
    #1;
    check("t2_gap_busy", 64'(busy), 64'(0));
    check("t2_i_arready", 64'(i_arready), 64'(1));
    check("t2_gap_d_arready", 64'(d_arready), 64'(0));
    tick();
    i_arvalid = 1'b0;

    // Address stall: fields stable, no handshakes even with a fresh D request.
    d_araddr = 32'h8000_3000; d_arvalid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("t3_arvalid", 64'(arvalid), 64'(1));
      check("t3_araddr", 64'(araddr), 64'h8000_2000);
      check("t3_arlen", 64'(arlen), 64'(7));
      check("t3_arid", 64'(arid), 64'(0));
      check("t3_no_arready", 64'({i_arready, d_arready}), 64'(0));
      tick();
    end
    d_arvalid = 1'b0;
    check("t3_arsize_i", 64'(arsize), 64'(2));
    arready = 1'b1;
    tick();
    arready = 1'b0;

    // Reset during beat 2 of the I burst.
    run_beats(1'b0, 2, 99, 32'hB000_0000, -1);
    rvalid = 1'b1; rdata = 32'hB000_0002; i_rready = 1'b1; resetn = 1'b0;
    tick();
    resetn = 1'b1; rvalid = 1'b0; rdata = '0; i_rready = 1'b0;
    #1;
    check("t5_arvalid", 64'(arvalid), 64'(0));
    check("t5_rready", 64'(rready), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_araddr", 64'(araddr), 64'(0));
    tick();

`ifdef BEAT_CHK_EN
    // Early rlast: arlen=3 but rlast on beat 2.
    check("t6_err_before", 64'(beat_err), 64'(0));
    i_araddr = 32'h0000_4000; i_arlen = 4'd3; i_arvalid = 1'b1;
    tick();
    i_arvalid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    run_beats(1'b0, 3, 2, 32'hC000_0000, -1);
    #1;
    check("t6_beat_err", 64'(beat_err), 64'(1));
    check("t6_busy", 64'(busy), 64'(0));
    tick();
    tick();
    check("t6_beat_err_sticky", 64'(beat_err), 64'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Sequential read-channel arbiter sharing one AXI3 read port between the I-cache and D-cache refill engines.
- Allows one outstanding read burst at a time. Grants one requester, registers its AR fields, and drives them to the bus until accepted.
- Steers the R channel to the granted requester until the last beat, then re-arbitrates.
- Sits between the cache refill FSMs and the CPU top-level AXI interface; write channels bypass it.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ISIZE, 3'b010, fixed arsize for I-cache requests.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- i_araddr  in  ADDR_W  I-cache read address
- i_arlen  in  4  I-cache burst length minus 1
- i_arvalid  in  1  I-cache request
- i_arready  out  1  I-cache request accepted
- i_rdata  out  DATA_W  I-cache read data
- i_rlast  out  1  I-cache last beat
- i_rvalid  out  1  I-cache data valid
- i_rready  in  1  I-cache data ready
- d_araddr  in  ADDR_W  D-cache read address
- d_arlen  in  4  D-cache burst length minus 1
- d_arsize  in  3  D-cache beat size
- d_arvalid  in  1  D-cache request
- d_arready  out  1  D-cache request accepted
- d_rdata  out  DATA_W  D-cache read data
- d_rlast  out  1  D-cache last beat
- d_rvalid  out  1  D-cache data valid
- d_rready  in  1  D-cache data ready
- arid  out  4  {3'b0, owner}; owner 1 = D-cache
- araddr  out  ADDR_W  registered address
- arlen  out  4  registered length
- arsize  out  3  registered size
- arburst  out  2  constant 2'b01 (INCR)
- arlock / arcache / arprot  out  2/4/3  constant 0
- arvalid  out  1  bus request
- arready  in  1  bus request accepted
- rid  in  4  unused for routing
- rdata  in  DATA_W  bus data
- rresp  in  2  unused
- rlast  in  1  bus last beat
- rvalid  in  1  bus data valid
- rready  out  1  bus data ready
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; synchronous active-low reset resetn.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any x_arvalid, the winner's x_arready = 1 combinationally in that cycle.
  - araddr/arlen/arsize/owner are registered on that edge; next state is ADDR.
  - I-cache arsize = ISIZE.
  - Loser's arready = 0; it must hold its request.
- ADDR:
  - arvalid = 1 with stable registered fields.
  - On arvalid & arready, go to DATA.
  - Minimum latency: request cycle 0, arvalid cycle 1, earliest DATA cycle 2.
- DATA:
  - rready = owner's x_rready.
  - Owner sees rdata/rlast/rvalid directly, combinationally.
  - Non-owner sees rvalid = 0, rlast = 0, rdata = 0.
  - On rvalid & rready & rlast, go to IDLE.
  - Re-arbitration is possible in that IDLE cycle, so there is one idle cycle between bursts.
- Beat counter:
  - 4-bit, cleared entering DATA, increments per R handshake.
  - rlast is authoritative; the counter only drives the BEAT_CHK_EN check.
- Outside DATA: rready = 0 and all x_rvalid = 0. Stray R beats are not consumed or forwarded.
- Only one x_arready is high in any cycle. x_arready is never high outside IDLE.
- Priority: D-cache wins when both request in the same IDLE cycle.
- Reset values:
  - state IDLE; arvalid, rready, busy, i_/d_arready, i_/d_rvalid, i_/d_rlast all 0.
  - araddr 0, arlen 0, arsize 0, owner 0, beat counter 0.
- Reset asserted mid-burst: return to IDLE next edge, drop arvalid/rready. Bus cleanup is the system reset's responsibility.
- Requester dropping arvalid while not granted: legal, no effect.

Optional Feature:
- Macro: BEAT_CHK_EN.
- Defined:
  - Adds output beat_err (1 bit, reset 0).
  - Set sticky on an R handshake where rlast != (beat_cnt == arlen). Cleared only by reset.
  - Has no effect on state transitions.
- Undefined: no beat_err port and no comparator; the beat counter is optimised away.

Test Plan:
- Single I request: i_araddr=0x1FC00000, i_arlen=7, arready=1 at cycle 1, 8 beats with rready=1:
  - i_arready=1 cycle 0; arvalid=1 cycle 1 with araddr=0x1FC00000, arlen=7, arsize=3'b010, arid=0.
  - 8 beats reach I only; busy falls after beat 8.
- Simultaneous requests, D (0x80001000, len 3, size 2) and I (0x80002000, len 7):
  - D granted first with arid=1; I held until D's rlast.
  - I granted in the following IDLE cycle with arid=0.
- arready held low 5 cycles in ADDR:
  - arvalid stays 1 with araddr/arlen unchanged.
  - No x_arready pulses.
- Owner D stalls d_rready=0 for 3 cycles mid-burst:
  - rready=0 in those cycles; no beat lost.
  - i_rvalid stays 0 throughout.
- resetn=0 for one cycle at beat 2 of an I burst: next cycle state=IDLE, arvalid=0, rready=0, busy=0.
- BEAT_CHK_EN, arlen=3 with rlast on beat 2: beat_err=1 and stays 1; state returns to IDLE.
